// File: rtl/periph_arb_pkg.sv
// Shared types and helpers for the peripheral TX arbiter.
package periph_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // First bit of the source-channel tag when tagging is enabled
  localparam int TAG_LSB = 28;

  // Index width for n channels, never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: returns the first set request bit
// strictly after `last`, wrapping around; `last` itself is checked last.
module rr_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] index
);

  // Scan offsets 1..N from the previous owner, keep the first hit
  always_comb begin
    int unsigned c;
    logic [W-1:0] idx;
    found = 1'b0;
    index = last;
    c     = 0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      c   = (int'(last) + k) % N;
      idx = W'(c);
      if (!found && req[idx]) begin
        found = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/periph_tx_arbiter.sv
// Round-robin arbiter sharing the host-bound TX path among peripheral
// channels, with bounded burst ownership and a one-word output register.
// Optional build macro PERIPH_TX_ARB_TAG_EN: stamps the source channel
// into data_o[31:28] and forces be_o[3] on every loaded word.
module periph_tx_arbiter
  import periph_arb_pkg::*;
#(
  parameter int NUM_PERIPH = 4,
  parameter int MAX_BURST  = 16,
  localparam int IW        = id_width(NUM_PERIPH)
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic [NUM_PERIPH-1:0]   periph_valid,
  input  logic [NUM_PERIPH*32-1:0] periph_data,
  input  logic [NUM_PERIPH*4-1:0] periph_be,
  output logic [NUM_PERIPH-1:0]   periph_ack,
  output logic [31:0]             data_o,
  output logic [3:0]              be_o,
  output logic                    periph_data_available,
  input  logic                    read_periph_data,
  output logic [IW-1:0]           grant_id,
  output logic                    busy
);

  localparam int BW    = $clog2(MAX_BURST + 1);
  localparam int TAG_W = 32 - TAG_LSB;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  arb_state_t state, state_nx;
  logic [BW-1:0] burst_cnt;
  logic [NUM_PERIPH-1:0][31:0] pdata;
  logic [NUM_PERIPH-1:0][3:0]  pbe;
  logic          load_en, take, found;
  logic [IW-1:0] pick;
  logic [31:0]   load_d;
  logic [3:0]    load_be;

  assign pdata = periph_data;
  assign pbe   = periph_be;

  rr_select #(.N(NUM_PERIPH), .W(IW)) u_sel (
    .req   (periph_valid),
    .last  (grant_id),
    .found (found),
    .index (pick)
  );

  // Output register can accept a word when empty or being drained now
  assign load_en = !periph_data_available | read_periph_data;
  // Owner's word is taken; gated by reset so nothing is acked in a reset cycle
  assign take    = rst_l & (state == GRANT) & periph_valid[grant_id] & load_en;
  assign busy    = (state == GRANT) | periph_data_available;

`ifdef PERIPH_TX_ARB_TAG_EN
  assign load_d  = {TAG_W'(grant_id), pdata[grant_id][TAG_LSB-1:0]};
  assign load_be = pbe[grant_id] | 4'b1000;
`else
  assign load_d  = pdata[grant_id];
  assign load_be = pbe[grant_id];
`endif

  // One-hot ack to the current owner only
  always_comb begin
    periph_ack = '0;
    if (take) periph_ack[grant_id] = 1'b1;
  end

  // Next state: pick in IDLE, release on owner drop or final burst beat
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (found) state_nx = GRANT;
      GRANT: begin
        if (!periph_valid[grant_id])            state_nx = IDLE;
        else if (take && burst_cnt == LAST_BEAT) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nx;
  end

  // Owner index and per-ownership word count
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      grant_id  <= IW'(NUM_PERIPH - 1);
      burst_cnt <= '0;
    end else if (state == IDLE && found) begin
      grant_id  <= pick;
      burst_cnt <= '0;
    end else if (take) begin
      burst_cnt <= burst_cnt + BW'(1);
    end
  end

  // Output word register; a load and a read on the same edge keep it full
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      data_o                <= '0;
      be_o                  <= '0;
      periph_data_available <= 1'b0;
    end else if (take) begin
      data_o                <= load_d;
      be_o                  <= load_be;
      periph_data_available <= 1'b1;
    end else if (read_periph_data) begin
      periph_data_available <= 1'b0;
    end
  end

endmodule

// File: tb/tb_periph_tx_arbiter.sv
// Random + directed bench for periph_tx_arbiter with a transaction-level
// reference model and a scoreboard drained by an independent monitor.
module tb_periph_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_l;
  logic [N-1:0]      periph_valid;
  logic [N*32-1:0]   periph_data;
  logic [N*4-1:0]    periph_be;
  logic [N-1:0]      periph_ack;
  logic [31:0]       data_o;
  logic [3:0]        be_o;
  logic              periph_data_available;
  logic              read_periph_data;
  logic [IW-1:0]     grant_id;
  logic              busy;

  always #5 clk = ~clk;

  periph_tx_arbiter #(.NUM_PERIPH(N), .MAX_BURST(MB)) dut (
    .clk                   (clk),
    .rst_l                 (rst_l),
    .periph_valid          (periph_valid),
    .periph_data           (periph_data),
    .periph_be             (periph_be),
    .periph_ack            (periph_ack),
    .data_o                (data_o),
    .be_o                  (be_o),
    .periph_data_available (periph_data_available),
    .read_periph_data      (read_periph_data),
    .grant_id              (grant_id),
    .busy                  (busy)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  be;
  } word_t;

  word_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  // Per-channel head-of-queue words presented to the DUT
  logic [31:0] head_d[N];
  logic [3:0]  head_be[N];
  bit          seq_mode = 1'b0;

  // Reference model: who owns the path, how many words taken, output reg
  bit          m_grant;
  int          m_owner;
  int          m_cnt;
  bit          m_avail;
  logic [31:0] m_d;
  logic [3:0]  m_be;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t xform(input int ch, input logic [31:0] d, input logic [3:0] be);
    word_t w;
    logic [31:0] chv;
    chv = ch;
`ifdef PERIPH_TX_ARB_TAG_EN
    w.d  = {chv[3:0], d[27:0]};
    w.be = be | 4'b1000;
`else
    w.d  = d | (chv & 32'h0);
    w.be = be;
`endif
    return w;
  endfunction

  task automatic advance(input int ch);
    if (seq_mode) head_d[ch] = head_d[ch] + 32'd1;
    else          head_d[ch] = $urandom;
    head_be[ch] = 4'($urandom_range(0, 15));
  endtask

  // One clock: drive inputs, check DUT against model, step model, cross edge
  task automatic cycle(input bit r, input logic [N-1:0] v, input bit rd);
    logic [N-1:0] exp_ack;
    bit           load_en;
    word_t        w;
    int           c;
    int           taken;
    rst_l            = r;
    periph_valid     = v;
    read_periph_data = rd;
    for (int i = 0; i < N; i++) begin
      periph_data[32*i +: 32] = head_d[i];
      periph_be[4*i +: 4]     = head_be[i];
    end
    #1;
    load_en = !m_avail || rd;
    exp_ack = '0;
    if (r && m_grant && v[m_owner] && load_en) exp_ack[m_owner] = 1'b1;
    check("ack", periph_ack, exp_ack);
    check("grant_id", grant_id, m_owner);
    check("available", periph_data_available, m_avail);
    check("busy", busy, m_grant || m_avail);
    if (m_avail) begin
      check("data_o", data_o, m_d);
      check("be_o", be_o, m_be);
    end
    taken = -1;
    if (!r) begin
      m_grant = 0; m_owner = N - 1; m_cnt = 0; m_avail = 0; m_d = '0; m_be = '0;
      sb.delete();
    end else begin
      if (m_avail && rd) m_avail = 0;
      if (!m_grant) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_owner + k) % N;
          if (v[c]) begin
            m_owner = c; m_cnt = 0; m_grant = 1;
            break;
          end
        end
      end else if (!v[m_owner]) begin
        m_grant = 0;
      end else if (load_en) begin
        w = xform(m_owner, head_d[m_owner], head_be[m_owner]);
        sb.push_back(w);
        m_d = w.d; m_be = w.be; m_avail = 1;
        m_cnt++;
        if (m_cnt == MB) m_grant = 0;
        taken = m_owner;
      end
    end
    @(posedge clk);
    #2;
    if (taken >= 0) advance(taken);
  endtask

  // Monitor: every word the consumer reads must be the next scoreboard entry
  initial begin
    forever begin
      @(negedge clk);
      if (rst_l === 1'b1 && periph_data_available === 1'b1 && read_periph_data === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: got word %0h expected none", data_o);
        end else begin
          word_t w;
          w = sb.pop_front();
          check("mon_data", data_o, w.d);
          check("mon_be", be_o, w.be);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] v;
    bit r, rd;
    for (int i = 0; i < N; i++) begin
      head_d[i]  = $urandom;
      head_be[i] = 4'($urandom_range(0, 15));
    end
    m_grant = 0; m_owner = N - 1; m_cnt = 0; m_avail = 0; m_d = '0; m_be = '0;
    rst_l = 1'b0; periph_valid = '1; read_periph_data = 1'b1;
    periph_data = '0; periph_be = '0;
    @(posedge clk); #2;

    // Reset held with every channel requesting
    repeat (3) cycle(0, 4'hF, 1);
    check("rst_data_o", data_o, 32'h0);
    check("rst_be_o", be_o, 4'h0);
    // Release: channel 0 must win first, then drop everyone
    repeat (2) cycle(1, 4'hF, 1);
    repeat (4) cycle(1, 4'h0, 1);

    // Single channel with a known sequence
    seq_mode = 1'b1;
    head_d[2] = 32'hA000_0001; head_be[2] = 4'hF;
    repeat (4) cycle(1, 4'b0100, 1);
    repeat (4) cycle(1, 4'h0, 1);

    // Tag / passthrough check on an all-ones word with sparse enables
    head_d[1] = 32'hFFFF_FFFF; head_be[1] = 4'b0001;
    repeat (2) cycle(1, 4'b0010, 1);
    repeat (4) cycle(1, 4'h0, 1);
    seq_mode = 1'b0;

    // Burst cap: two channels always requesting, consumer always ready
    repeat (30) cycle(1, 4'b0011, 1);
    // Backpressure mid-burst, then resume
    repeat (5) cycle(1, 4'b0011, 0);
    repeat (10) cycle(1, 4'b0011, 1);
    repeat (4) cycle(1, 4'h0, 1);

    // Owner drop on ch3 with wrap to ch1
    repeat (3) cycle(1, 4'b1000, 1);
    repeat (6) cycle(1, 4'b0010, 1);
    repeat (4) cycle(1, 4'h0, 1);

    // Random traffic with occasional mid-burst reset
    for (int n = 0; n < 2000; n++) begin
      v  = N'($urandom) & N'($urandom | $urandom);
      rd = ($urandom_range(0, 99) < 70);
      r  = ($urandom_range(0, 299) != 0);
      cycle(r, v, rd);
    end

    // Drain
    repeat (10) cycle(1, 4'h0, 1);
    check("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
